vrf_bank_arbiter: RTL and testbench

Per-lane arbiter that shares the banked vector register file between all requesters of the lane: operand requesters (reads) and the ALU, MFPU, load unit and slide unit result paths (writes). Each cycle it grants at most one requester per bank and drives the VRF bank ports. It uses two priority classes with per-bank round-robin fairness, and promotes a starved low-priority requester to the high class after a bounded wait. It sits between the lane's operand requester / result queues and the VRF, which returns read data one cycle after a granted read.

---
 rtl/ara_pkg.sv | 30 +++
 rtl/vrf_bank_rr_arb.sv | 66 ++++++
 rtl/vrf_bank_arbiter.sv | 117 +++++++++++
 tb/tb_vrf_bank_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ara_pkg.sv
// ara_pkg: lane-wide types shared by the VRF arbiter and its neighbours.
//   NrVRFBanks  - number of VRF banks in a lane
//   elen_t      - one VRF element word
//   strb_t      - byte enables for an elen_t
//   vaddr_t     - VRF address; low log2(NrVRFBanks) bits select the bank
//   opqueue_e   - operand queue that receives read data
//   vrf_req_t   - one VRF access as it travels from a requester to a bank
package ara_pkg;

    localparam int unsigned NrVRFBanks = 8;
    localparam int unsigned ELEN       = 64;
    localparam int unsigned VAddrW     = 16;

    typedef logic [ELEN-1:0]   elen_t;
    typedef logic [ELEN/8-1:0] strb_t;
    typedef logic [VAddrW-1:0] vaddr_t;

    typedef enum logic [2:0] {
        AluA, AluB, AluC, MulFPUA, MulFPUB, MulFPUC, StA, SlideAddrGenA
    } opqueue_e;

    typedef struct packed {
        vaddr_t   addr;
        logic     wen;
        elen_t    wdata;
        strb_t    be;
        opqueue_e tgt_opqueue;
    } vrf_req_t;

endpackage

// File: rtl/vrf_bank_rr_arb.sv
// vrf_bank_rr_arb: two-class round-robin arbiter for one VRF bank.
//   clk_i, rst_i - clock, synchronous active-high reset
//   cand_i       - requesters currently targeting this bank
//   hi_i         - effective high class per requester (native or promoted)
//   win_o        - one-hot winner, all zero when there is no candidate
// Holds one round-robin pointer per class; only the winning class's
// pointer advances, and only on a grant.
module vrf_bank_rr_arb
    import ara_pkg::*;
#(
    parameter int unsigned NrReq = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NrReq-1:0] cand_i,
    input  logic [NrReq-1:0] hi_i,
    output logic [NrReq-1:0] win_o
);

    localparam int PtrW = (NrReq > 1) ? $clog2(NrReq) : 1;

    logic [PtrW-1:0]  ptr_hi, ptr_lo, ptr, win_idx, ptr_nxt;
    logic [NrReq-1:0] hi_cand, lo_cand, pool;
    logic             use_hi, found;

    assign hi_cand = cand_i & hi_i;
    assign lo_cand = cand_i & ~hi_i;
    // The low class is only served when no high candidate is present.
    assign use_hi  = |hi_cand;
    assign pool    = use_hi ? hi_cand : lo_cand;
    assign ptr     = use_hi ? ptr_hi : ptr_lo;

    // First pass covers [ptr, NrReq-1], second pass wraps to [0, ptr-1].
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        win_o   = '0;
        for (int i = 0; i < NrReq; i++) begin
            if (!found && pool[i] && (PtrW'(i) >= ptr)) begin
                found    = 1'b1;
                win_idx  = PtrW'(i);
                win_o[i] = 1'b1;
            end
        end
        for (int i = 0; i < NrReq; i++) begin
            if (!found && pool[i]) begin
                found    = 1'b1;
                win_idx  = PtrW'(i);
                win_o[i] = 1'b1;
            end
        end
    end

    assign ptr_nxt = (win_idx == PtrW'(NrReq - 1)) ? '0 : win_idx + PtrW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_hi <= '0;
            ptr_lo <= '0;
        end else if (found) begin
            if (use_hi) ptr_hi <= ptr_nxt;
            else        ptr_lo <= ptr_nxt;
        end
    end

endmodule

// File: rtl/vrf_bank_arbiter.sv
// vrf_bank_arbiter: shares the lane's banked VRF between all requesters.
//   clk_i, rst_i        - clock, synchronous active-high reset
//   req_i, hi_prio_i    - request valid and native high class per requester
//   addr_i, wen_i, wdata_i, be_i, tgt_opqueue_i - request payload
//   gnt_o               - same-cycle grant per requester
//   vrf_req_o, vrf_addr_o, vrf_wen_o, vrf_wdata_o, vrf_be_o,
//   vrf_tgt_opqueue_o   - per-bank port, carrying the winner's payload or '0
// Low-class requesters that stall MaxStall cycles are promoted to the
// high class until they are granted or drop their request.
module vrf_bank_arbiter
    import ara_pkg::*;
#(
    parameter int unsigned NrBanks  = NrVRFBanks,
    parameter int unsigned NrReq    = 10,
    parameter int unsigned MaxStall = 15
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic     [NrReq-1:0]      req_i,
    input  logic     [NrReq-1:0]      hi_prio_i,
    input  vaddr_t   [NrReq-1:0]      addr_i,
    input  logic     [NrReq-1:0]      wen_i,
    input  elen_t    [NrReq-1:0]      wdata_i,
    input  strb_t    [NrReq-1:0]      be_i,
    input  opqueue_e [NrReq-1:0]      tgt_opqueue_i,
    output logic     [NrReq-1:0]      gnt_o,
    output logic     [NrBanks-1:0]    vrf_req_o,
    output vaddr_t   [NrBanks-1:0]    vrf_addr_o,
    output logic     [NrBanks-1:0]    vrf_wen_o,
    output elen_t    [NrBanks-1:0]    vrf_wdata_o,
    output strb_t    [NrBanks-1:0]    vrf_be_o,
    output opqueue_e [NrBanks-1:0]    vrf_tgt_opqueue_o
);

    localparam int BankW = $clog2(NrBanks);
    localparam int CntW  = $clog2(MaxStall + 1);

    logic     [NrBanks-1:0][NrReq-1:0] cand, win;
    logic     [NrReq-1:0]              promoted, cls_hi;
    logic     [NrReq-1:0][CntW-1:0]    stall_cnt;
    vrf_req_t [NrReq-1:0]              req_pl;
    vrf_req_t [NrBanks-1:0]            bank_pl;

    // Candidates are masked during reset so grants and bank ports stay idle.
    always_comb begin
        for (int b = 0; b < NrBanks; b++) begin
            for (int r = 0; r < NrReq; r++) begin
                cand[b][r] = req_i[r] && !rst_i &&
                             (addr_i[r][BankW-1:0] == BankW'(b));
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NrReq; r++) begin
            promoted[r] = (stall_cnt[r] == CntW'(MaxStall));
            cls_hi[r]   = hi_prio_i[r] || promoted[r];
        end
    end

    for (genvar b = 0; b < NrBanks; b++) begin : g_bank
        vrf_bank_rr_arb #(
            .NrReq (NrReq)
        ) i_arb (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .cand_i (cand[b]),
            .hi_i   (cls_hi),
            .win_o  (win[b])
        );
    end

    // Each requester targets a single bank, so OR-ing the banks' one-hot
    // winners never yields two grants for the same requester.
    always_comb begin
        gnt_o = '0;
        for (int b = 0; b < NrBanks; b++) gnt_o = gnt_o | win[b];
    end

    always_comb begin
        for (int r = 0; r < NrReq; r++) begin
            req_pl[r] = '{addr:        addr_i[r],
                          wen:         wen_i[r],
                          wdata:       wdata_i[r],
                          be:          be_i[r],
                          tgt_opqueue: tgt_opqueue_i[r]};
        end
    end

    always_comb begin
        for (int b = 0; b < NrBanks; b++) begin
            bank_pl[b] = '0;
            for (int r = 0; r < NrReq; r++) begin
                if (win[b][r]) bank_pl[b] = req_pl[r];
            end
            vrf_req_o[b]         = |win[b];
            vrf_addr_o[b]        = bank_pl[b].addr;
            vrf_wen_o[b]         = bank_pl[b].wen;
            vrf_wdata_o[b]       = bank_pl[b].wdata;
            vrf_be_o[b]          = bank_pl[b].be;
            vrf_tgt_opqueue_o[b] = bank_pl[b].tgt_opqueue;
        end
    end

    // Native high requesters never count; a promoted requester holds at
    // MaxStall until it is served or squashes its request.
    always_ff @(posedge clk_i) begin
        for (int r = 0; r < NrReq; r++) begin
            if (rst_i || !req_i[r] || gnt_o[r]) begin
                stall_cnt[r] <= '0;
            end else if (!hi_prio_i[r] && !promoted[r]) begin
                stall_cnt[r] <= stall_cnt[r] + CntW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vrf_bank_arbiter.sv
// tb_vrf_bank_arbiter: directed scenarios plus randomized traffic for
// vrf_bank_arbiter, compared cycle by cycle with a behavioural model.
module tb_vrf_bank_arbiter;
    import ara_pkg::*;

    localparam int NB = 8;
    localparam int NR = 10;
    localparam int MS = 15;

    logic                 clk = 1'b0;
    logic                 rst;
    logic     [NR-1:0]    req, hi, wen;
    vaddr_t   [NR-1:0]    addr;
    elen_t    [NR-1:0]    wdata;
    strb_t    [NR-1:0]    be;
    opqueue_e [NR-1:0]    opq;
    logic     [NR-1:0]    gnt_o;
    logic     [NB-1:0]    vrf_req_o, vrf_wen_o;
    vaddr_t   [NB-1:0]    vrf_addr_o;
    elen_t    [NB-1:0]    vrf_wdata_o;
    strb_t    [NB-1:0]    vrf_be_o;
    opqueue_e [NB-1:0]    vrf_tgt_opqueue_o;

    int nchk = 0;
    int nerr = 0;

    // Model state: round-robin pointers per bank/class and stall counts.
    int m_ptr_hi [NB];
    int m_ptr_lo [NB];
    int m_wait   [NR];
    // Model outputs for the current cycle.
    logic [NR-1:0] exp_gnt;
    logic [NB-1:0] exp_vreq;
    int            exp_win [NB];
    bit            exp_cls [NB];

    vrf_bank_arbiter #(.NrBanks(NB), .NrReq(NR), .MaxStall(MS)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_i             (req),
        .hi_prio_i         (hi),
        .addr_i            (addr),
        .wen_i             (wen),
        .wdata_i           (wdata),
        .be_i              (be),
        .tgt_opqueue_i     (opq),
        .gnt_o             (gnt_o),
        .vrf_req_o         (vrf_req_o),
        .vrf_addr_o        (vrf_addr_o),
        .vrf_wen_o         (vrf_wen_o),
        .vrf_wdata_o       (vrf_wdata_o),
        .vrf_be_o          (vrf_be_o),
        .vrf_tgt_opqueue_o (vrf_tgt_opqueue_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish (got running, need finished)");
        $fatal(1);
    end

    function automatic int bank_of(int r);
        return int'(addr[r]) % NB;
    endfunction

    function automatic bit eff_hi(int r);
        return hi[r] || (m_wait[r] >= MS);
    endfunction

    task automatic model_eval();
        int  p, r;
        bit  any_hi;
        exp_gnt  = '0;
        exp_vreq = '0;
        for (int b = 0; b < NB; b++) begin
            exp_win[b] = -1;
            exp_cls[b] = 1'b0;
        end
        if (rst) return;
        for (int b = 0; b < NB; b++) begin
            any_hi = 1'b0;
            for (int i = 0; i < NR; i++)
                if (req[i] && bank_of(i) == b && eff_hi(i)) any_hi = 1'b1;
            p = any_hi ? m_ptr_hi[b] : m_ptr_lo[b];
            for (int k = 0; k < NR; k++) begin
                r = (p + k) % NR;
                if (exp_win[b] < 0 && req[r] && bank_of(r) == b && eff_hi(r) == any_hi)
                    exp_win[b] = r;
            end
            if (exp_win[b] >= 0) begin
                exp_gnt[exp_win[b]] = 1'b1;
                exp_vreq[b]         = 1'b1;
                exp_cls[b]          = any_hi;
            end
        end
    endtask

    task automatic model_step();
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                m_ptr_hi[b] = 0;
                m_ptr_lo[b] = 0;
            end
            for (int r = 0; r < NR; r++) m_wait[r] = 0;
            return;
        end
        for (int b = 0; b < NB; b++) begin
            if (exp_win[b] >= 0) begin
                if (exp_cls[b]) m_ptr_hi[b] = (exp_win[b] + 1) % NR;
                else            m_ptr_lo[b] = (exp_win[b] + 1) % NR;
            end
        end
        for (int r = 0; r < NR; r++) begin
            if (!req[r] || exp_gnt[r]) m_wait[r] = 0;
            else if (!hi[r] && m_wait[r] < MS) m_wait[r] = m_wait[r] + 1;
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        req = '0; hi = '0; wen = '0; addr = '0; wdata = '0; be = '0;
        for (int r = 0; r < NR; r++) opq[r] = AluA;
    endtask

    task automatic new_payload(int r, int bank);
        addr[r]  = vaddr_t'(($urandom_range(0, 8191) << 3) | bank);
        wen[r]   = 1'($urandom_range(0, 1));
        wdata[r] = {$urandom, $urandom};
        be[r]    = strb_t'($urandom);
        opq[r]   = opqueue_e'($urandom_range(0, 7));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        settle();
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        for (int r = 0; r < NR; r++) new_payload(r, r % NB);
        req = '1;
        settle();
        nchk++;
        if (gnt_o !== '0) begin
            nerr++; $display("FAIL reset_gnt: got %h need 0", gnt_o);
        end
        nchk++;
        if (vrf_req_o !== '0 || vrf_addr_o !== '0 || vrf_wen_o !== '0 ||
            vrf_wdata_o !== '0 || vrf_be_o !== '0) begin
            nerr++; $display("FAIL reset_ports: got req=%h addr=%h need all 0", vrf_req_o, vrf_addr_o);
        end
        advance();
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_single_read();
        clear_inputs();
        req[3] = 1'b1; addr[3] = 16'h0025; wen[3] = 1'b0; opq[3] = MulFPUB;
        settle();
        nchk++;
        if (gnt_o !== 10'h008) begin
            nerr++; $display("FAIL single_gnt: got %h need 008", gnt_o);
        end
        nchk++;
        if (vrf_req_o !== 8'h20 || vrf_addr_o[5] !== 16'h0025 || vrf_wen_o[5] !== 1'b0 ||
            vrf_tgt_opqueue_o[5] !== MulFPUB) begin
            nerr++; $display("FAIL single_port: got req=%h addr=%h wen=%b opq=%0d need 20 0025 0 %0d",
                             vrf_req_o, vrf_addr_o[5], vrf_wen_o[5], vrf_tgt_opqueue_o[5], MulFPUB);
        end
        advance();
        clear_inputs();
    endtask

    task automatic test_bank_conflict();
        int            seq [4] = '{1, 4, 7, 1};
        logic [NR-1:0] want;
        clear_inputs();
        foreach (seq[i]) begin
            req[seq[i]] = 1'b1; hi[seq[i]] = 1'b1;
            new_payload(seq[i], 2);
        end
        for (int i = 0; i < 4; i++) begin
            settle();
            want = '0;
            want[seq[i]] = 1'b1;
            nchk++;
            if (gnt_o !== want) begin
                nerr++; $display("FAIL conflict_order[%0d]: got %h need %h", i, gnt_o, want);
            end
            nchk++;
            if (gnt_o !== exp_gnt) begin
                nerr++; $display("FAIL conflict_model[%0d]: got %h need %h", i, gnt_o, exp_gnt);
            end
            advance();
        end
        clear_inputs();
    endtask

    task automatic test_parallel_banks();
        int b;
        clear_inputs();
        for (int r = 0; r < NB; r++) begin
            req[r] = 1'b1;
            hi[r]  = 1'($urandom_range(0, 1));
            new_payload(r, (r + 3) % NB);
        end
        settle();
        nchk++;
        if (gnt_o !== 10'h0FF || vrf_req_o !== 8'hFF) begin
            nerr++; $display("FAIL parallel_gnt: got gnt=%h req=%h need 0ff ff", gnt_o, vrf_req_o);
        end
        for (int r = 0; r < NB; r++) begin
            b = (r + 3) % NB;
            nchk++;
            if (vrf_addr_o[b] !== addr[r] || vrf_wen_o[b] !== wen[r] || vrf_wdata_o[b] !== wdata[r] ||
                vrf_be_o[b] !== be[r] || vrf_tgt_opqueue_o[b] !== opq[r]) begin
                nerr++; $display("FAIL parallel_payload bank %0d: got addr=%h need %h", b, vrf_addr_o[b], addr[r]);
            end
        end
        advance();
        clear_inputs();
    endtask

    task automatic test_priority();
        int first6 = -1;
        clear_inputs();
        do_reset();
        req[2] = 1'b1; hi[2] = 1'b1; new_payload(2, 0);
        req[6] = 1'b1; hi[6] = 1'b0; new_payload(6, 0);
        for (int c = 0; c < 20 && first6 < 0; c++) begin
            settle();
            nchk++;
            if (gnt_o !== exp_gnt) begin
                nerr++; $display("FAIL prio_model[%0d]: got %h need %h", c, gnt_o, exp_gnt);
            end
            if (c < 15) begin
                nchk++;
                if (gnt_o !== 10'h004) begin
                    nerr++; $display("FAIL prio_hi_wins[%0d]: got %h need 004", c, gnt_o);
                end
            end
            if (gnt_o[6]) first6 = c;
            advance();
        end
        nchk++;
        if (first6 < 15 || first6 > 16) begin
            nerr++; $display("FAIL prio_promotion: req6 granted at cycle %0d need 15..16", first6);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        do_reset();
        foreach (req[r]) if (r == 1 || r == 4 || r == 7) begin
            req[r] = 1'b1; hi[r] = 1'b1; new_payload(r, 2);
        end
        settle(); advance();
        settle(); advance();
        rst = 1'b1;
        settle();
        nchk++;
        if (gnt_o !== '0 || vrf_req_o !== '0) begin
            nerr++; $display("FAIL rstmid_idle: got gnt=%h req=%h need 0 0", gnt_o, vrf_req_o);
        end
        advance();
        rst = 1'b0;
        settle();
        nchk++;
        if (gnt_o !== 10'h002) begin
            nerr++; $display("FAIL rstmid_ptr0: got %h need 002", gnt_o);
        end
        advance();
        clear_inputs();
    endtask

    task automatic test_squash();
        clear_inputs();
        do_reset();
        req[2] = 1'b1; hi[2] = 1'b1; new_payload(2, 1);
        req[5] = 1'b1; hi[5] = 1'b0; new_payload(5, 1);
        for (int c = 0; c < 10; c++) begin
            settle();
            nchk++;
            if (gnt_o !== exp_gnt || gnt_o[5] !== 1'b0) begin
                nerr++; $display("FAIL squash_wait[%0d]: got %h need %h", c, gnt_o, exp_gnt);
            end
            advance();
        end
        req[5] = 1'b0;
        settle();
        advance();
        req[5] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            settle();
            nchk++;
            if (gnt_o !== exp_gnt) begin
                nerr++; $display("FAIL squash_model[%0d]: got %h need %h", k, gnt_o, exp_gnt);
            end
            nchk++;
            if (gnt_o[5] !== (k == 15)) begin
                nerr++; $display("FAIL squash_restart[%0d]: got gnt5=%b need %b", k, gnt_o[5], (k == 15));
            end
            advance();
        end
        clear_inputs();
    endtask

    task automatic test_random();
        int run [NR];
        int w;
        clear_inputs();
        do_reset();
        for (int r = 0; r < NR; r++) begin
            run[r] = 0;
            hi[r]  = ($urandom_range(0, 9) < 3);
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int r = 0; r < NR; r++) begin
                if (!req[r]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        req[r] = 1'b1;
                        new_payload(r, $urandom_range(0, NB - 1));
                    end
                end else if ($urandom_range(0, 99) < 3) begin
                    req[r] = 1'b0;
                    run[r] = 0;
                end
            end
            settle();
            nchk++;
            if (gnt_o !== exp_gnt || vrf_req_o !== exp_vreq) begin
                nerr++; $display("FAIL rand_gnt[%0d]: got gnt=%h req=%h need %h %h",
                                 cyc, gnt_o, vrf_req_o, exp_gnt, exp_vreq);
            end
            for (int b = 0; b < NB; b++) begin
                w = exp_win[b];
                nchk++;
                if (w >= 0) begin
                    if (vrf_addr_o[b] !== addr[w] || vrf_wen_o[b] !== wen[w] ||
                        vrf_wdata_o[b] !== wdata[w] || vrf_be_o[b] !== be[w] ||
                        vrf_tgt_opqueue_o[b] !== opq[w]) begin
                        nerr++; $display("FAIL rand_payload[%0d] bank %0d: got addr=%h need %h",
                                         cyc, b, vrf_addr_o[b], addr[w]);
                    end
                end else if (vrf_addr_o[b] !== '0 || vrf_wen_o[b] !== 1'b0 ||
                             vrf_wdata_o[b] !== '0 || vrf_be_o[b] !== '0 ||
                             vrf_tgt_opqueue_o[b] !== AluA) begin
                    nerr++; $display("FAIL rand_idle[%0d] bank %0d: got addr=%h need 0",
                                     cyc, b, vrf_addr_o[b]);
                end
            end
            for (int r = 0; r < NR; r++) begin
                if (req[r] && exp_gnt[r] && !hi[r]) begin
                    nchk++;
                    if (run[r] > MS + NR) begin
                        nerr++; $display("FAIL starve_bound req %0d: waited %0d need <= %0d",
                                         r, run[r], MS + NR);
                    end
                end
            end
            advance();
            for (int r = 0; r < NR; r++) begin
                if (req[r] && exp_gnt[r]) begin
                    req[r] = 1'b0;
                    run[r] = 0;
                end else if (req[r]) begin
                    run[r] = run[r] + 1;
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        for (int b = 0; b < NB; b++) begin
            m_ptr_hi[b] = 0;
            m_ptr_lo[b] = 0;
        end
        for (int r = 0; r < NR; r++) m_wait[r] = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_bank_conflict();
        test_parallel_banks();
        test_priority();
        test_reset_mid();
        test_squash();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
